booth_seq_mul: RTL



---
 rtl/booth_seq_mul_pkg.sv | 40 ++++
 rtl/booth_seq_mul_if.sv | 42 ++++
 rtl/booth_r4_pp.sv | 33 +++
 rtl/booth_seq_mul.sv | 116 +++++++++++
 4 files changed

// File: rtl/booth_seq_mul_pkg.sv
// ============================================================================
// mulx_pkg : shared types and helpers for booth_seq_mul (MULX_UNSIGNED_EN)
// Revision : 1.0
// ============================================================================
`default_nettype none

package mulx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // One-hot radix-4 Booth digit: magnitude selects x1/x2, neg flips the sign.
  typedef struct packed {
    logic neg;
    logic x1;
    logic x2;
  } booth_digit_t;

  function automatic int n_steps(input int width);
`ifdef MULX_UNSIGNED_EN
    return width / 2 + 1;
`else
    return width / 2;
`endif
  endfunction

  function automatic booth_digit_t booth_encode(input logic [2:0] bits);
    booth_digit_t d;
    d.neg = bits[2] & ~(bits[1] & bits[0]);
    d.x1  = bits[1] ^ bits[0];
    d.x2  = (bits[2] & ~bits[1] & ~bits[0]) | (~bits[2] & bits[1] & bits[0]);
    return d;
  endfunction

endpackage

`default_nettype wire

// File: rtl/booth_seq_mul_if.sv
// ============================================================================
// booth_seq_mul_if : operand/result handshake bundle (MULX_UNSIGNED_EN)
// Revision : 1.0
// ============================================================================
`default_nettype none

interface booth_seq_mul_if #(
  parameter int WIDTH = 32
);
  logic                   en;
  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   out_valid;
  logic                   out_ready;
  logic [2*WIDTH-1:0]     result;
  logic                   busy;
`ifdef MULX_UNSIGNED_EN
  logic                   sign_mode;

  modport master (
    output en, in_valid, a, b, out_ready, sign_mode,
    input  in_ready, out_valid, result, busy
  );
  modport slave (
    input  en, in_valid, a, b, out_ready, sign_mode,
    output in_ready, out_valid, result, busy
  );
`else
  modport master (
    output en, in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, busy
  );
  modport slave (
    input  en, in_valid, a, b, out_ready,
    output in_ready, out_valid, result, busy
  );
`endif
endinterface

`default_nettype wire

// File: rtl/booth_r4_pp.sv
// ============================================================================
// booth_r4_pp : combinational radix-4 Booth partial-product generator
// Revision : 1.0
// ============================================================================
`default_nettype none

module booth_r4_pp
  import mulx_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  wire logic [2:0]       bits,
  input  wire logic [WIDTH:0]   mcand,
  output logic      [WIDTH+1:0] pp
);

  booth_digit_t          w_digit;
  logic [WIDTH+1:0]      w_mag;

  // mcand is already extended by one bit, so 2*mcand always fits WIDTH+2 bits
  always_comb begin
    w_digit = booth_encode(bits);
    w_mag   = '0;
    if (w_digit.x2)
      w_mag = {mcand, 1'b0};
    else if (w_digit.x1)
      w_mag = {mcand[WIDTH], mcand};
    pp = w_digit.neg ? (~w_mag + 1'b1) : w_mag;
  end

endmodule

`default_nettype wire

// File: rtl/booth_seq_mul.sv
// ============================================================================
// booth_seq_mul : sequential radix-4 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH
// Optional MULX_UNSIGNED_EN adds sign_mode (1 = signed, 0 = unsigned).
// Revision : 1.0
// ============================================================================
`default_nettype none

module booth_seq_mul
  import mulx_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  wire logic       clk,
  input  wire logic       reset,
  booth_seq_mul_if.slave  bus
);

  localparam int STEPS = n_steps(WIDTH);
  localparam int LW    = 2 * STEPS;          // product bits shifted out of the accumulator
  localparam int MW    = LW + 1;             // recoded multiplier plus the b[-1] bit
  localparam int HW    = WIDTH + 4;          // upper accumulator with overflow headroom
  localparam int HR    = 2 * WIDTH - LW;     // upper bits that land in the result
  localparam int CW    = $clog2(STEPS + 1);

  state_t                r_state;
  logic [CW-1:0]         r_cnt;
  logic [WIDTH:0]        r_mcand;
  logic [MW-1:0]         r_mplr;
  logic [HW-1:0]         r_hi;
  logic [LW-1:0]         r_lo;
  logic [2*WIDTH-1:0]    r_result;
  logic                  r_out_valid;
  logic                  r_busy;

  logic [WIDTH:0]        w_a_ext;
  logic [LW-1:0]         w_b_ext;
  logic [WIDTH+1:0]      w_pp;
  logic [HW-1:0]         w_sum;
  logic [HW-1:0]         w_hi_nxt;
  logic [LW-1:0]         w_lo_nxt;

`ifdef MULX_UNSIGNED_EN
  logic                  w_sext;
  assign w_sext  = bus.sign_mode;
  assign w_a_ext = {w_sext & bus.a[WIDTH-1], bus.a};
  assign w_b_ext = {{2{w_sext & bus.b[WIDTH-1]}}, bus.b};
`else
  assign w_a_ext = {bus.a[WIDTH-1], bus.a};
  assign w_b_ext = bus.b;
`endif

  booth_r4_pp #(.WIDTH(WIDTH)) u_pp (
    .bits  (r_mplr[2:0]),
    .mcand (r_mcand),
    .pp    (w_pp)
  );

  assign w_sum    = r_hi + {{(HW-WIDTH-2){w_pp[WIDTH+1]}}, w_pp};
  assign w_hi_nxt = {{2{w_sum[HW-1]}}, w_sum[HW-1:2]};
  assign w_lo_nxt = {w_sum[1:0], r_lo[LW-1:2]};

  assign bus.in_ready  = bus.en && (r_state == IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.result    = r_result;
  assign bus.busy      = r_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_mcand     <= '0;
      r_mplr      <= '0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else if (bus.en) begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_mcand <= w_a_ext;
            r_mplr  <= {w_b_ext, 1'b0};
            r_hi    <= '0;
            r_lo    <= '0;
            r_cnt   <= CW'(STEPS);
            r_busy  <= 1'b1;
            r_state <= BUSY;
          end
        end
        BUSY: begin
          r_hi   <= w_hi_nxt;
          r_lo   <= w_lo_nxt;
          r_mplr <= {2'b00, r_mplr[MW-1:2]};
          r_cnt  <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_result    <= {w_hi_nxt[HR-1:0], w_lo_nxt};
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
